// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM/IO bus master arbitrating instruction fetch and load/store buffer
module mem_ctrl #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback_signal,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        ena_from_if,
    input  logic [31:0] addr_from_if,
    output logic        rdy_to_if,
    output logic [31:0] inst_to_if,
    input  logic        ena_from_lsb,
    input  logic        wr_from_lsb,
    input  logic [31:0] addr_from_lsb,
    input  logic [2:0]  len_from_lsb,
    input  logic [31:0] data_from_lsb,
    output logic        rdy_to_lsb,
    output logic [7:0]  data_to_lsb
);

    typedef enum logic [1:0] {IDLE, IF_RD, LSB_RD, LSB_WR} state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  issue_q, issue_d;     // bytes whose address has been put on the bus
    logic [2:0]  recv_q, recv_d;       // read bytes already captured
    logic        drive_q, drive_d;     // mem_a this cycle is a live read
    logic        rd_v_q, rd_v_d;       // mem_din this cycle belongs to the transfer
    logic [23:0] inst_buf_q, inst_buf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        rdy_to_if_q, rdy_to_if_d;
    logic [31:0] inst_q, inst_d;
    logic        rdy_to_lsb_q, rdy_to_lsb_d;
    logic [7:0]  data_to_lsb_q, data_to_lsb_d;

    logic        wr_step;
    logic [31:0] wr_base;
    logic [31:0] wr_word;
    logic [2:0]  wr_issue;
    logic [31:0] wr_addr;
    logic [31:0] wr_shift;
    logic [2:0]  lsb_len;

    assign lsb_len = (len_from_lsb == 3'd0) ? 3'd1 : len_from_lsb;

    // Next-state and next-output computation; every output comes straight from a register
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        word_d        = word_q;
        issue_d       = issue_q;
        recv_d        = recv_q;
        drive_d       = drive_q;
        rd_v_d        = rd_v_q;
        inst_buf_d    = inst_buf_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        mem_wr_d      = 1'b0;
        rdy_to_if_d   = 1'b0;
        inst_d        = inst_q;
        rdy_to_lsb_d  = 1'b0;
        data_to_lsb_d = data_to_lsb_q;
        wr_step       = 1'b0;
        wr_base       = base_q;
        wr_word       = word_q;
        wr_issue      = issue_q;
        wr_addr       = 32'd0;
        wr_shift      = 32'd0;

        case (state_q)
            IDLE: begin
                drive_d = 1'b0;
                rd_v_d  = 1'b0;
                // A pulse cycle is the requester's drop edge, so its ena is stale
                if (!(rdy_to_if_q || rdy_to_lsb_q)) begin
                    if (ena_from_lsb && wr_from_lsb) begin
                        // A store is already committed, so a rollback does not cancel it
                        base_d   = addr_from_lsb;
                        len_d    = lsb_len;
                        word_d   = data_from_lsb;
                        issue_d  = 3'd0;
                        recv_d   = 3'd0;
                        state_d  = LSB_WR;
                        wr_step  = 1'b1;
                        wr_base  = addr_from_lsb;
                        wr_word  = data_from_lsb;
                        wr_issue = 3'd0;
                    end else if (!rollback_signal && (ena_from_lsb || ena_from_if)) begin
                        base_d  = ena_from_lsb ? addr_from_lsb : addr_from_if;
                        len_d   = ena_from_lsb ? lsb_len : 3'd4;
                        state_d = ena_from_lsb ? LSB_RD : IF_RD;
                        mem_a_d = base_d;
                        issue_d = 3'd1;
                        recv_d  = 3'd0;
                        drive_d = 1'b1;
                    end
                end
            end
            IF_RD, LSB_RD: begin
                if (rollback_signal) begin
                    state_d = IDLE;
                    drive_d = 1'b0;
                    rd_v_d  = 1'b0;
                end else begin
                    if (issue_q < len_q) begin
                        mem_a_d = base_q + {29'd0, issue_q};
                        issue_d = issue_q + 3'd1;
                        drive_d = 1'b1;
                    end else begin
                        drive_d = 1'b0;
                    end
                    rd_v_d = drive_q;
                    if (rd_v_q) begin
                        recv_d     = recv_q + 3'd1;
                        inst_buf_d = {mem_din, inst_buf_q[23:8]};
                        if (state_q == LSB_RD) begin
                            data_to_lsb_d = mem_din;
                            rdy_to_lsb_d  = 1'b1;
                        end
                        if (recv_d == len_q) begin
                            state_d = IDLE;
                            if (state_q == IF_RD) begin
                                inst_d      = {mem_din, inst_buf_q};
                                rdy_to_if_d = 1'b1;
                            end
                        end
                    end
                end
            end
            LSB_WR: begin
                if (issue_q < len_q) begin
                    wr_step = 1'b1;
                end else begin
                    rdy_to_lsb_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // One store byte per cycle, held back while the IO buffer cannot take it
        if (wr_step) begin
            wr_addr = wr_base + {29'd0, wr_issue};
            if (!((wr_addr[17:16] == IO_ADDR_HI) && io_buffer_full)) begin
                wr_shift   = wr_word >> {wr_issue, 3'b000};
                mem_a_d    = wr_addr;
                mem_dout_d = wr_shift[7:0];
                mem_wr_d   = 1'b1;
                issue_d    = wr_issue + 3'd1;
            end
        end
    end

    // State register; rdy low freezes everything in step with the RAM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= 32'd0;
            len_q         <= 3'd0;
            word_q        <= 32'd0;
            issue_q       <= 3'd0;
            recv_q        <= 3'd0;
            drive_q       <= 1'b0;
            rd_v_q        <= 1'b0;
            inst_buf_q    <= 24'd0;
            mem_a_q       <= 32'd0;
            mem_dout_q    <= 8'd0;
            mem_wr_q      <= 1'b0;
            rdy_to_if_q   <= 1'b0;
            inst_q        <= 32'd0;
            rdy_to_lsb_q  <= 1'b0;
            data_to_lsb_q <= 8'd0;
        end else if (rdy) begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            word_q        <= word_d;
            issue_q       <= issue_d;
            recv_q        <= recv_d;
            drive_q       <= drive_d;
            rd_v_q        <= rd_v_d;
            inst_buf_q    <= inst_buf_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            mem_wr_q      <= mem_wr_d;
            rdy_to_if_q   <= rdy_to_if_d;
            inst_q        <= inst_d;
            rdy_to_lsb_q  <= rdy_to_lsb_d;
            data_to_lsb_q <= data_to_lsb_d;
        end
    end

    assign mem_a       = mem_a_q;
    assign mem_dout    = mem_dout_q;
    assign mem_wr      = mem_wr_q;
    assign rdy_to_if   = rdy_to_if_q;
    assign inst_to_if  = inst_q;
    assign rdy_to_lsb  = rdy_to_lsb_q;
    assign data_to_lsb = data_to_lsb_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with a RAM model and reference memory
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback_signal;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;
    logic        ena_from_if;
    logic [31:0] addr_from_if;
    logic        rdy_to_if;
    logic [31:0] inst_to_if;
    logic        ena_from_lsb, wr_from_lsb;
    logic [31:0] addr_from_lsb;
    logic [2:0]  len_from_lsb;
    logic [31:0] data_from_lsb;
    logic        rdy_to_lsb;
    logic [7:0]  data_to_lsb;

    int tests = 0;
    int fails = 0;

    mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .ena_from_if(ena_from_if), .addr_from_if(addr_from_if),
        .rdy_to_if(rdy_to_if), .inst_to_if(inst_to_if),
        .ena_from_lsb(ena_from_lsb), .wr_from_lsb(wr_from_lsb),
        .addr_from_lsb(addr_from_lsb), .len_from_lsb(len_from_lsb),
        .data_from_lsb(data_from_lsb), .rdy_to_lsb(rdy_to_lsb), .data_to_lsb(data_to_lsb)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ix(input logic [31:0] a);
        return {a[17:16], a[12:0]};
    endfunction

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // RAM environment: 1-cycle read latency, pauses with rdy
    logic [7:0]  ram [0:32767];
    bit          ram_vld [0:32767];
    logic        pre_we = 1'b0;
    logic [31:0] pre_a = 32'd0;
    logic [7:0]  pre_d = 8'd0;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[ix(pre_a)]     <= pre_d;
            ram_vld[ix(pre_a)] <= 1'b1;
        end
        if (rdy) begin
            mem_din <= ram_vld[ix(mem_a)] ? ram[ix(mem_a)] : init_byte(mem_a);
            if (mem_wr) begin
                ram[ix(mem_a)]     <= mem_dout;
                ram_vld[ix(mem_a)] <= 1'b1;
            end
        end
    end

    // Reference memory: what the RAM should hold according to completed stores
    logic [7:0] ref_mem [0:32767];
    bit         ref_vld [0:32767];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_vld[ix(a)] ? ref_mem[ix(a)] : init_byte(a);
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [7:0] d);
        ref_mem[ix(a)] = d;
        ref_vld[ix(a)] = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [31:0] a, input logic [7:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        step();
        pre_we = 1'b0;
        ref_wr(a, d);
    endtask

    // Load of len bytes; rb = cycle (relative to c) carrying rollback, fz = cycle frozen for 3 edges
    task automatic lsb_load(input logic [31:0] a, input logic [2:0] len, input int rb, input int fz);
        int  n, reps;
        bit  live;
        n = (len == 3'd0) ? 1 : int'(len);
        ena_from_lsb = 1'b1; wr_from_lsb = 1'b0; addr_from_lsb = a; len_from_lsb = len;
        step();
        for (int j = 0; j <= n + 2; j++) begin
            if (j == n + 1 || (rb >= 0 && j == rb + 1)) ena_from_lsb = 1'b0;
            live = (rb < 0) || (j <= rb);
            rollback_signal = (j == rb);
            reps = (j == fz) ? 4 : 1;
            for (int r = 0; r < reps; r++) begin
                if (j < n && live) begin
                    chk("ld_addr", mem_a, a + j);
                    chk("ld_wr", mem_wr, 1'b0);
                end
                chk("ld_rdy", rdy_to_lsb, (j >= 2 && j <= n + 1 && live));
                if (j >= 2 && j <= n + 1 && live) chk("ld_data", data_to_lsb, ref_rd(a + j - 2));
                chk("ld_if_rdy", rdy_to_if, 1'b0);
                rdy = (r < reps - 1) ? 1'b0 : 1'b1;
                step();
            end
        end
        rollback_signal = 1'b0;
        ena_from_lsb = 1'b0;
    endtask

    task automatic lsb_store(input logic [31:0] a, input logic [2:0] len, input logic [31:0] d,
                             input int rb, input bit rb_acc);
        int n;
        logic [31:0] sh;
        n = (len == 3'd0) ? 1 : int'(len);
        ena_from_lsb = 1'b1; wr_from_lsb = 1'b1; addr_from_lsb = a; len_from_lsb = len;
        data_from_lsb = d; rollback_signal = rb_acc;
        step();
        data_from_lsb = $urandom;
        for (int j = 0; j <= n + 1; j++) begin
            if (j == n) ena_from_lsb = 1'b0;
            rollback_signal = (j == rb);
            if (j < n) begin
                sh = d >> (8 * j);
                chk("st_addr", mem_a, a + j);
                chk("st_wr", mem_wr, 1'b1);
                chk("st_dout", mem_dout, sh[7:0]);
            end else begin
                chk("st_wr_idle", mem_wr, 1'b0);
            end
            chk("st_rdy", rdy_to_lsb, (j == n));
            chk("st_if_rdy", rdy_to_if, 1'b0);
            step();
        end
        rollback_signal = 1'b0;
        for (int k = 0; k < n; k++) begin
            sh = d >> (8 * k);
            ref_wr(a + k, sh[7:0]);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int rb);
        logic [31:0] w;
        bit live;
        w = {ref_rd(a + 3), ref_rd(a + 2), ref_rd(a + 1), ref_rd(a)};
        ena_from_if = 1'b1; addr_from_if = a;
        step();
        for (int j = 0; j <= 6; j++) begin
            if (j == 5 || (rb >= 0 && j == rb + 1)) ena_from_if = 1'b0;
            live = (rb < 0) || (j <= rb);
            rollback_signal = (j == rb);
            if (j < 4 && live) begin
                chk("if_addr", mem_a, a + j);
                chk("if_wr", mem_wr, 1'b0);
            end
            chk("if_rdy", rdy_to_if, (j == 5 && live));
            if (j == 5 && live) chk("if_inst", inst_to_if, w);
            chk("if_lsb_rdy", rdy_to_lsb, 1'b0);
            step();
        end
        rollback_signal = 1'b0;
        ena_from_if = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC + $urandom_range(0, 3);
        return 32'h0000_1000 + $urandom_range(0, 31);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] ln;
        logic [31:0] a;
        int op, n, rb, fz;

        rst = 1'b1; rdy = 1'b1; rollback_signal = 1'b0; io_buffer_full = 1'b0;
        ena_from_if = 1'b0; addr_from_if = 32'd0;
        ena_from_lsb = 1'b0; wr_from_lsb = 1'b0; addr_from_lsb = 32'd0;
        len_from_lsb = 3'd0; data_from_lsb = 32'd0;
        step(); step(); step();
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", mem_dout, 8'd0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_rdy_if", rdy_to_if, 1'b0);
        chk("rst_inst", inst_to_if, 32'd0);
        chk("rst_rdy_lsb", rdy_to_lsb, 1'b0);
        chk("rst_data_lsb", data_to_lsb, 8'd0);
        rst = 1'b0;
        step();

        // Word load and word fetch from preset RAM
        preset(32'h100, 8'h11); preset(32'h101, 8'h22); preset(32'h102, 8'h33); preset(32'h103, 8'h44);
        preset(32'h0, 8'h13); preset(32'h1, 8'h05); preset(32'h2, 8'h00); preset(32'h3, 8'h00);
        lsb_load(32'h100, 3'd4, -1, -1);
        fetch(32'h0, -1);

        // Simultaneous requests: LSB first, IF accepted one idle cycle after LSB's last pulse
        ena_from_if = 1'b1; addr_from_if = 32'h0;
        ena_from_lsb = 1'b1; wr_from_lsb = 1'b0; addr_from_lsb = 32'h100; len_from_lsb = 3'd2;
        step();
        for (int j = 0; j <= 11; j++) begin
            if (j == 3) ena_from_lsb = 1'b0;
            if (j == 10) ena_from_if = 1'b0;
            if (j < 2) chk("pri_lsb_addr", mem_a, 32'h100 + j);
            if (j >= 5 && j < 9) chk("pri_if_addr", mem_a, j - 5);
            chk("pri_wr", mem_wr, 1'b0);
            chk("pri_lsb_rdy", rdy_to_lsb, (j == 2 || j == 3));
            if (j == 2 || j == 3) chk("pri_lsb_data", data_to_lsb, ref_rd(32'h100 + j - 2));
            chk("pri_if_rdy", rdy_to_if, (j == 10));
            if (j == 10) chk("pri_if_inst", inst_to_if, 32'h0000_0513);
            step();
        end

        // Word store, then read back with a rdy freeze in the middle
        lsb_store(32'h200, 3'd4, 32'hDEAD_BEEF, -1, 1'b0);
        lsb_load(32'h200, 3'd4, -1, 2);
        lsb_load(32'h200, 3'd0, -1, -1);

        // IO-region byte store held off while the UART buffer is full
        io_buffer_full = 1'b1;
        ena_from_lsb = 1'b1; wr_from_lsb = 1'b1; addr_from_lsb = 32'h0003_0000;
        len_from_lsb = 3'd1; data_from_lsb = 32'h0000_00A5;
        step();
        for (int j = 0; j <= 5; j++) begin
            if (j == 2) io_buffer_full = 1'b0;
            if (j == 4) ena_from_lsb = 1'b0;
            chk("io_wr", mem_wr, (j == 3));
            if (j == 3) begin
                chk("io_addr", mem_a, 32'h0003_0000);
                chk("io_dout", mem_dout, 8'hA5);
            end
            chk("io_rdy", rdy_to_lsb, (j == 4));
            step();
        end
        ref_wr(32'h0003_0000, 8'hA5);
        io_buffer_full = 1'b1;
        lsb_load(32'h0003_0000, 3'd1, -1, -1);
        io_buffer_full = 1'b0;

        // Rollbacks: abort a fetch, complete a store, refuse a load at acceptance
        fetch(32'h0, 1);
        fetch(32'h100, -1);
        lsb_store(32'h1000, 3'd4, 32'h0BAD_F00D, 1, 1'b0);
        lsb_load(32'h1000, 3'd4, -1, -1);
        lsb_load(32'h1004, 3'd4, 3, -1);
        ena_from_lsb = 1'b1; wr_from_lsb = 1'b0; addr_from_lsb = 32'h1020;
        len_from_lsb = 3'd2; rollback_signal = 1'b1;
        step();
        rollback_signal = 1'b0;
        chk("rb_acc_addr", (mem_a == 32'h1020), 1'b0);
        chk("rb_acc_rdy", rdy_to_lsb, 1'b0);
        lsb_load(32'h1020, 3'd2, -1, -1);
        lsb_store(32'h1024, 3'd2, 32'h1234_5678, -1, 1'b1);
        lsb_load(32'h1024, 3'd2, -1, -1);

        // Address wrap at the top of the space
        lsb_store(32'hFFFF_FFFE, 3'd4, 32'hCAFE_1234, -1, 1'b0);
        fetch(32'hFFFF_FFFE, -1);

        // Reset in the middle of a fetch
        ena_from_if = 1'b1; addr_from_if = 32'h1000;
        step();
        step();
        ena_from_if = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_mem_a", mem_a, 32'd0);
        chk("mid_rst_inst", inst_to_if, 32'd0);
        chk("mid_rst_data", data_to_lsb, 8'd0);
        for (int j = 0; j < 6; j++) begin
            chk("mid_rst_no_rdy", rdy_to_if, 1'b0);
            step();
        end

        // Randomized traffic against the reference memory
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 2);
            a = rand_addr();
            case ($urandom_range(0, 3))
                0: ln = 3'd0;
                1: ln = 3'd1;
                2: ln = 3'd2;
                default: ln = 3'd4;
            endcase
            n = (ln == 3'd0) ? 1 : int'(ln);
            rb = -1;
            fz = -1;
            if (op == 0) begin
                case ($urandom_range(0, 3))
                    0: rb = $urandom_range(0, n + 1);
                    1: fz = $urandom_range(0, n + 2);
                    default: ;
                endcase
                lsb_load(a, ln, rb, fz);
            end else if (op == 1) begin
                if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, n - 1);
                lsb_store(a, ln, $urandom, rb, 1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 5);
                fetch(a, rb);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
